// File: rtl/memory_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int WMASK_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of instruction, data and shared-memory request/response signals.
// Latency: n/a (wires only).
// Backpressure: valid/ready on the three request channels, responses are unthrottled pulses.
// Modports: master = requesters plus memory (environment side), slave = the arbiter.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  // instruction fetch channel
  logic               i_req_valid;
  logic               i_req_ready;
  logic [ADDR_W-1:0]  i_req_addr;
  logic               i_kill;
  logic               i_resp_valid;
  logic [ADDR_W-1:0]  i_resp_addr;
  logic [DATA_W-1:0]  i_resp_inst;

  // data channel
  logic               d_req_valid;
  logic               d_req_ready;
  logic [ADDR_W-1:0]  d_req_addr;
  logic               d_req_wen;
  logic [DATA_W-1:0]  d_req_wdata;
  logic [WMASK_W-1:0] d_req_wmask;
  logic               d_resp_valid;
  logic [ADDR_W-1:0]  d_resp_addr;
  logic [DATA_W-1:0]  d_resp_rdata;

  // shared memory port
  logic               m_req_valid;
  logic               m_req_ready;
  logic [ADDR_W-1:0]  m_req_addr;
  logic               m_req_wen;
  logic [DATA_W-1:0]  m_req_wdata;
  logic [WMASK_W-1:0] m_req_wmask;
  logic               m_resp_valid;
  logic [DATA_W-1:0]  m_resp_rdata;

  modport master (
    output i_req_valid, i_req_addr, i_kill,
    output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wmask,
    output m_req_ready, m_resp_valid, m_resp_rdata,
    input  i_req_ready, i_resp_valid, i_resp_addr, i_resp_inst,
    input  d_req_ready, d_resp_valid, d_resp_addr, d_resp_rdata,
    input  m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wmask
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_kill,
    input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wmask,
    input  m_req_ready, m_resp_valid, m_resp_rdata,
    output i_req_ready, i_resp_valid, i_resp_addr, i_resp_inst,
    output d_req_ready, d_resp_valid, d_resp_addr, d_resp_rdata,
    output m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wmask
  );

endinterface

// File: rtl/memory_arbiter_starve_counter.sv
// Counts consecutive data grants taken while an instruction fetch waits; flags when the limit is hit.
// Latency: count updates one cycle after the grant; starve_hit is a direct decode of the count.
// Backpressure: none, observes grants only.
// Ports: clk/rst_n, idle (arbiter in IDLE), i_req_valid, i_grant/d_grant (accepted memory request), starve_hit.
module arb_starve_counter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic i_req_valid,
  input  logic i_grant,
  input  logic d_grant,
  output logic starve_hit
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (i_grant || (idle && !i_req_valid)) begin
      cnt <= '0;
    end else if (d_grant && i_req_valid && (cnt != LIMIT)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign starve_hit = (cnt == LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one memory port, one request outstanding at a time.
// Latency: request passes through combinationally in IDLE; response passes through in the cycle it arrives.
// Backpressure: winner's ready follows m_req_ready in IDLE, both readies low while a request is outstanding.
// Ports: clk, rst_n (async, active-low), bus (memory_arbiter_if.slave).
// Build option: define ARBITER_FAIRNESS_EN to let a starved instruction fetch win after STARVE_LIMIT data grants.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  memory_arbiter_if.slave  bus
);

  arb_state_t        state;
  logic [ADDR_W-1:0] lat_addr;
  logic              discard;
  logic              idle;
  logic              grant_i;
  logic              i_pri;
  logic              m_vld;
  logic              m_fire;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("memory_arbiter: STARVE_LIMIT must be in 1..15");
  end

  assign idle    = (state == IDLE);
  assign grant_i = bus.i_req_valid & (~bus.d_req_valid | i_pri);
  // outputs are forced low while reset is asserted, independent of the clock
  assign m_vld   = rst_n & idle & (bus.i_req_valid | bus.d_req_valid);
  assign m_fire  = m_vld & bus.m_req_ready;

`ifdef ARBITER_FAIRNESS_EN
  logic starve_hit;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk         (clk),
    .rst_n       (rst_n),
    .idle        (idle),
    .i_req_valid (bus.i_req_valid),
    .i_grant     (m_fire & grant_i),
    .d_grant     (m_fire & ~grant_i),
    .starve_hit  (starve_hit)
  );

  assign i_pri = starve_hit;
`else
  assign i_pri = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_addr <= '0;
      discard  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (m_fire) begin
            lat_addr <= grant_i ? bus.i_req_addr : bus.d_req_addr;
            state    <= grant_i ? WAIT_I : WAIT_D;
          end
        end
        WAIT_I: begin
          if (bus.m_resp_valid) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (bus.i_kill) begin
            discard <= 1'b1;
          end
        end
        WAIT_D: begin
          if (bus.m_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // request side: mux the winner onto the memory port; instruction fetches never write
  always_comb begin
    bus.m_req_valid = m_vld;
    bus.m_req_addr  = '0;
    bus.m_req_wen   = 1'b0;
    bus.m_req_wdata = '0;
    bus.m_req_wmask = '0;
    bus.i_req_ready = 1'b0;
    bus.d_req_ready = 1'b0;
    if (rst_n && idle) begin
      if (grant_i) begin
        bus.m_req_addr  = bus.i_req_addr;
        bus.i_req_ready = bus.m_req_ready;
      end else begin
        bus.m_req_addr  = bus.d_req_addr;
        bus.m_req_wen   = bus.d_req_wen;
        bus.m_req_wdata = bus.d_req_wdata;
        bus.m_req_wmask = bus.d_req_wmask;
        bus.d_req_ready = bus.m_req_ready;
      end
    end
  end

  // response side: a kill in the arrival cycle drops the response just like an earlier kill
  always_comb begin
    bus.i_resp_valid = rst_n & (state == WAIT_I) & bus.m_resp_valid & ~discard & ~bus.i_kill;
    bus.d_resp_valid = rst_n & (state == WAIT_D) & bus.m_resp_valid;
    bus.i_resp_addr  = rst_n ? lat_addr : '0;
    bus.d_resp_addr  = rst_n ? lat_addr : '0;
    bus.i_resp_inst  = rst_n ? bus.m_resp_rdata : '0;
    bus.d_resp_rdata = rst_n ? bus.m_resp_rdata : '0;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if bus ();

  memory_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        m_rdy, i_vld, d_vld;
    logic        chk_fields;
    logic        exp_m_vld, exp_i_rdy, exp_d_rdy;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
  } vec_t;

  exp_t        exp_i_q[$];
  exp_t        exp_d_q[$];
  logic [31:0] grant_log[$];
  int          total = 0;
  int          bad = 0;

  bit          auto_resp = 1'b0;
  int          resp_lat = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  int          resp_cnt = 0;
  logic [31:0] resp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] grant_at(input int k);
    return (grant_log.size() > k) ? grant_log[k] : 32'hFFFF_FFFF;
  endfunction

  // memory model: one outstanding request, answers resp_lat cycles after acceptance
  initial begin
    bus.m_resp_valid = 1'b0;
    bus.m_resp_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.m_resp_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.m_resp_valid = 1'b1;
          bus.m_resp_rdata = resp_data;
        end
      end else if (auto_resp && bus.m_req_valid && bus.m_req_ready) begin
        grant_log.push_back(bus.m_req_addr);
        resp_data = ovr_en ? ovr_val : (bus.m_req_addr ^ KEY);
        resp_cnt  = resp_lat;
      end
    end
  end

  // response monitor: pops the per-channel scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (bus.i_resp_valid && bus.d_resp_valid) begin
        total++; bad++;
        $display("FAIL both_resp: got i and d responses together, want at most one");
      end
      if (bus.i_resp_valid) begin
        if (exp_i_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_i_resp: got addr=%h inst=%h, want no response", bus.i_resp_addr, bus.i_resp_inst);
        end else begin
          e = exp_i_q.pop_front();
          chk("i_resp_addr", bus.i_resp_addr, e.addr);
          chk("i_resp_inst", bus.i_resp_inst, e.data);
        end
      end
      if (bus.d_resp_valid) begin
        if (exp_d_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_d_resp: got addr=%h data=%h, want no response", bus.d_resp_addr, bus.d_resp_rdata);
        end else begin
          e = exp_d_q.pop_front();
          chk("d_resp_addr", bus.d_resp_addr, e.addr);
          chk("d_resp_rdata", bus.d_resp_rdata, e.data);
        end
      end
    end
  end

  task automatic drive_i(input logic [31:0] a, input bit expect_resp);
    bit ok = 1'b0;
    if (expect_resp) exp_i_q.push_back('{a, a ^ KEY});
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = a;
    for (int n = 0; n < 100 && !ok; n++) begin
      #1;
      if (bus.i_req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL i_handshake_timeout: addr %h got no ready, want ready within 100 cycles", a);
    end
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                         input logic [3:0] wm, input bit expect_resp);
    bit ok = 1'b0;
    if (expect_resp) exp_d_q.push_back('{a, a ^ KEY});
    @(negedge clk);
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = a;
    bus.d_req_wen   = wen;
    bus.d_req_wdata = wd;
    bus.d_req_wmask = wm;
    for (int n = 0; n < 100 && !ok; n++) begin
      #1;
      if (bus.d_req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL d_handshake_timeout: addr %h got no ready, want ready within 100 cycles", a);
    end
    @(posedge clk);
    #1;
    bus.d_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && (exp_i_q.size() != 0 || exp_d_q.size() != 0); n++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[6];
    logic [31:0] exp_order[4];

    #200000;
    $display("FAIL watchdog: simulation still running at 200000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] exp_order[4];

    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h100; bus.i_kill = 1'b0;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h2000; bus.d_req_wen = 1'b1;
    bus.d_req_wdata = 32'hCAFE_0000; bus.d_req_wmask = 4'hF;
    bus.m_req_ready = 1'b1;

    // reset holds every output low even with requests pending
    #3;
    chk("rst_m_req_valid", {31'b0, bus.m_req_valid}, 0);
    chk("rst_i_req_ready", {31'b0, bus.i_req_ready}, 0);
    chk("rst_d_req_ready", {31'b0, bus.d_req_ready}, 0);
    chk("rst_m_req_addr", bus.m_req_addr, 0);
    chk("rst_resp_valid", {30'b0, bus.i_resp_valid, bus.d_resp_valid}, 0);
    bus.i_req_valid = 1'b0; bus.d_req_valid = 1'b0; bus.m_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // combinational arbitration in IDLE; no handshake completes
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 4'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100,  1'b0, 4'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b1, 4'hF, 32'hCAFE_0000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b1, 4'hF, 32'hCAFE_0000};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 1'b1, 4'hF, 32'hCAFE_0000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100,  1'b0, 4'h0, 32'h0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.m_req_ready = vecs[k].m_rdy;
      bus.i_req_valid = vecs[k].i_vld;
      bus.d_req_valid = vecs[k].d_vld;
      #1;
      chk($sformatf("vec%0d_m_req_valid", k), {31'b0, bus.m_req_valid}, {31'b0, vecs[k].exp_m_vld});
      chk($sformatf("vec%0d_i_req_ready", k), {31'b0, bus.i_req_ready}, {31'b0, vecs[k].exp_i_rdy});
      if (vecs[k].m_rdy || vecs[k].i_vld || vecs[k].d_vld)
        chk($sformatf("vec%0d_d_req_ready", k), {31'b0, bus.d_req_ready}, {31'b0, vecs[k].exp_d_rdy});
      if (vecs[k].chk_fields) begin
        chk($sformatf("vec%0d_m_req_addr", k), bus.m_req_addr, vecs[k].exp_addr);
        chk($sformatf("vec%0d_m_req_wen", k), {31'b0, bus.m_req_wen}, {31'b0, vecs[k].exp_wen});
        chk($sformatf("vec%0d_m_req_wmask", k), {28'b0, bus.m_req_wmask}, {28'b0, vecs[k].exp_wmask});
        chk($sformatf("vec%0d_m_req_wdata", k), bus.m_req_wdata, vecs[k].exp_wdata);
      end
      #1;
      bus.i_req_valid = 1'b0;
      bus.d_req_valid = 1'b0;
      bus.m_req_ready = 1'b0;
    end

    bus.m_req_ready = 1'b1;
    auto_resp = 1'b1;

    // instruction read answered three cycles later with an overridden word
    resp_lat = 3; ovr_en = 1'b1; ovr_val = 32'h0000_0013;
    exp_i_q.push_back('{32'h100, 32'h0000_0013});
    drive_i(32'h100, 1'b0);
    ovr_en = 1'b0;
    drain();
    chk("ifetch_drained", exp_i_q.size(), 0);

    // conflict: data wins, instruction held off until the data response
    grant_log.delete();
    fork
      drive_i(32'h104, 1'b1);
      drive_d(32'h2000, 1'b0, 32'h0, 4'h0, 1'b1);
      begin
        @(negedge clk);
        #1 chk("conflict_i_ready_idle", {31'b0, bus.i_req_ready}, 0);
        @(negedge clk);
        #1 chk("conflict_i_ready_waitd", {31'b0, bus.i_req_ready}, 0);
      end
    join
    drain();
    chk("conflict_grant0", grant_at(0), 32'h2000);
    chk("conflict_grant1", grant_at(1), 32'h104);

    // write with i_kill held outside WAIT_I: data response still delivered
    resp_lat = 2;
    bus.i_kill = 1'b1;
    drive_d(32'h3000, 1'b1, 32'h1234_5678, 4'b0101, 1'b1);
    drain();
    bus.i_kill = 1'b0;
    drive_i(32'h108, 1'b1);
    drain();

    // starvation: instruction held while data issues back to back
    resp_lat = 1;
    grant_log.delete();
`ifdef ARBITER_FAIRNESS_EN
    exp_order[0] = 32'h5000; exp_order[1] = 32'h5004; exp_order[2] = 32'h400; exp_order[3] = 32'h5008;
`else
    exp_order[0] = 32'h5000; exp_order[1] = 32'h5004; exp_order[2] = 32'h5008; exp_order[3] = 32'h500C;
`endif
    fork
      drive_i(32'h400, 1'b1);
      for (int k = 0; k < 4; k++) drive_d(32'h5000 + 32'(4 * k), 1'b0, 32'h0, 4'h0, 1'b1);
    join
    drain();
    for (int k = 0; k < 4; k++) chk($sformatf("starve_grant%0d", k), grant_at(k), exp_order[k]);

    // kill during WAIT_I, then a new fetch is accepted right after the dropped response
    resp_lat = 3; ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h300;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0; ovr_en = 1'b0;
    @(negedge clk);
    bus.i_kill = 1'b1;
    @(negedge clk);
    bus.i_kill = 1'b0;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h200;
    #3 chk("kill_suppress", {31'b0, bus.i_resp_valid}, 0);
    @(negedge clk);
    #1 chk("kill_next_ready", {31'b0, bus.i_req_ready}, 1);
    exp_i_q.push_back('{32'h200, 32'h200 ^ KEY});
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    drain();
    chk("kill_drained", exp_i_q.size(), 0);

    // kill in the same cycle as the response: dropped, arbiter back to IDLE
    resp_lat = 2;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h308;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.i_kill = 1'b1;
    #3 chk("kill_same_cycle", {31'b0, bus.i_resp_valid}, 0);
    @(negedge clk);
    bus.i_kill = 1'b0;
    drive_i(32'h30C, 1'b1);
    drain();

    // asynchronous reset while the data response is on the bus
    @(negedge clk);
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h6000; bus.d_req_wen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 chk("pre_reset_d_resp", {31'b0, bus.d_resp_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_d_resp_drop", {31'b0, bus.d_resp_valid}, 0);
    chk("reset_d_ready_drop", {31'b0, bus.d_req_ready}, 0);
    chk("reset_m_req_valid", {31'b0, bus.m_req_valid}, 0);
    bus.d_req_valid = 1'b0;
    #1 rst_n = 1'b1;
    #2;
    chk("late_resp_ignored", {30'b0, bus.i_resp_valid, bus.d_resp_valid}, 0);
    drain();

    drive_i(32'h700, 1'b1);
    drain();
    chk("final_i_q_empty", exp_i_q.size(), 0);
    chk("final_d_q_empty", exp_d_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
